glitch_fault_monitor: RTL

- Response-side checker for the clock-glitch adder target.
- The stimulus side drives operands a/b into the glitched adder. This block receives the same operands plus the adder's finout.
- It recomputes the golden sum, aligns it to the target's pipeline latency and compares the two.
- It counts samples and faults, captures the first faulty sample, and can halt a campaign after a fault budget is spent.

---
 rtl/glitch_fault_monitor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/glitch_fault_monitor.sv
// Response-side checker for the clock-glitch adder target: delays a/b by LAT cycles and compares the golden sum with finout.
// Optional macro FAULT_BITMAP_EN adds the flip_map / flip_last bit-flip observation outputs.
module glitch_fault_monitor #(
  parameter int W          = 4,
  parameter int LAT        = 1,
  parameter int CNT_W      = 16,
  parameter int MAX_FAULTS = 0
) (
  input  logic             clk_in1,
  input  logic             rst,
  input  logic             arm,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       finout,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             ff_valid,
  output logic [W-1:0]     ff_a,
  output logic [W-1:0]     ff_b,
  output logic [W:0]       ff_exp,
  output logic [W:0]       ff_obs
`ifdef FAULT_BITMAP_EN
  ,
  output logic [W:0]       flip_map,
  output logic [W:0]       flip_last
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, halted_q, halted_d, fault_q, fault_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, fault_cnt_q, fault_cnt_d, fc_inc;
  logic             ff_valid_q, ff_valid_d;
  logic [W-1:0]     ff_a_q, ff_a_d, ff_b_q, ff_b_d;
  logic [W:0]       ff_exp_q, ff_exp_d, ff_obs_q, ff_obs_d;
  logic             flush, dv, cmp_v, mismatch;
  logic [W-1:0]     da, db;
  logic [W:0]       exp_sum, diff;
`ifdef FAULT_BITMAP_EN
  logic [W:0]       flip_map_q, flip_map_d, flip_last_q, flip_last_d;
`endif

  // Arming drops whatever is in flight so samples taken while idle never count.
  generate
    if (LAT == 0) begin : g_direct
      assign dv = in_valid;
      assign da = a;
      assign db = b;
    end else begin : g_pipe
      logic [LAT-1:0] v_q, v_d;
      logic [W-1:0]   a_q [LAT];
      logic [W-1:0]   a_d [LAT];
      logic [W-1:0]   b_q [LAT];
      logic [W-1:0]   b_d [LAT];

      always_comb begin
        v_d    = '0;
        v_d[0] = in_valid;
        a_d[0] = a;
        b_d[0] = b;
        for (int i = 1; i < LAT; i++) begin
          v_d[i] = v_q[i-1];
          a_d[i] = a_q[i-1];
          b_d[i] = b_q[i-1];
        end
        if (flush) v_d = '0;
      end

      always_ff @(posedge clk_in1) begin
        if (!rst) v_q <= '0;
        else      v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
      end

      assign dv = v_q[LAT-1];
      assign da = a_q[LAT-1];
      assign db = b_q[LAT-1];
    end
  endgenerate

  always_comb begin
    exp_sum  = {1'b0, da} + {1'b0, db};
    diff     = exp_sum ^ finout;
    cmp_v    = dv && (state_q == S_RUN) && !clr;
    mismatch = cmp_v && (diff != '0);
    fc_inc   = (fault_cnt_q == '1) ? fault_cnt_q : fault_cnt_q + CNT_W'(1);
    flush    = (state_q == S_IDLE) && arm && !clr;

    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    fault_d      = 1'b0;
    ff_valid_d   = ff_valid_q;
    ff_a_d       = ff_a_q;
    ff_b_d       = ff_b_q;
    ff_exp_d     = ff_exp_q;
    ff_obs_d     = ff_obs_q;
`ifdef FAULT_BITMAP_EN
    flip_map_d   = flip_map_q;
    flip_last_d  = flip_last_q;
`endif

    if (clr) begin
      state_d      = S_IDLE;
      sample_cnt_d = '0;
      fault_cnt_d  = '0;
      ff_valid_d   = 1'b0;
      ff_a_d       = '0;
      ff_b_d       = '0;
      ff_exp_d     = '0;
      ff_obs_d     = '0;
`ifdef FAULT_BITMAP_EN
      flip_map_d   = '0;
      flip_last_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (arm) state_d = S_RUN;
        S_RUN: begin
          if (cmp_v && sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
          if (mismatch) begin
            fault_cnt_d = fc_inc;
            fault_d     = 1'b1;
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_a_d     = da;
              ff_b_d     = db;
              ff_exp_d   = exp_sum;
              ff_obs_d   = finout;
            end
`ifdef FAULT_BITMAP_EN
            flip_map_d  = flip_map_q | diff;
            flip_last_d = diff;
`endif
            if (MAX_FAULTS != 0 && fc_inc == CNT_W'(MAX_FAULTS)) state_d = S_HALT;
          end
        end
        S_HALT: ;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d == S_RUN);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_in1) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      sample_cnt_q <= '0;
      fault_cnt_q  <= '0;
      ff_valid_q   <= 1'b0;
      ff_a_q       <= '0;
      ff_b_q       <= '0;
      ff_exp_q     <= '0;
      ff_obs_q     <= '0;
`ifdef FAULT_BITMAP_EN
      flip_map_q   <= '0;
      flip_last_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      sample_cnt_q <= sample_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      ff_valid_q   <= ff_valid_d;
      ff_a_q       <= ff_a_d;
      ff_b_q       <= ff_b_d;
      ff_exp_q     <= ff_exp_d;
      ff_obs_q     <= ff_obs_d;
`ifdef FAULT_BITMAP_EN
      flip_map_q   <= flip_map_d;
      flip_last_q  <= flip_last_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign sample_cnt = sample_cnt_q;
  assign fault_cnt  = fault_cnt_q;
  assign ff_valid   = ff_valid_q;
  assign ff_a       = ff_a_q;
  assign ff_b       = ff_b_q;
  assign ff_exp     = ff_exp_q;
  assign ff_obs     = ff_obs_q;
`ifdef FAULT_BITMAP_EN
  assign flip_map   = flip_map_q;
  assign flip_last  = flip_last_q;
`endif

endmodule
